fft_stage_scheduler: RTL and testbench



---
 rtl/fft_stage_scheduler_if.sv | 30 +++
 rtl/fft_stage_scheduler.sv | 169 ++++++++++++++++
 tb/tb_fft_stage_scheduler.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stage_scheduler_if.sv
// Butterfly descriptor and completion channel between the FFT stage scheduler
// (master) and the processing element (slave).
interface fft_stage_scheduler_if #(
  parameter int stages     = 10,
  parameter int stagesbits = 4,
  parameter int shamtbits  = 4
);
  logic                  op_valid_o;
  logic                  op_ready_i;
  logic [stages-1:0]     op_addr_a_o;
  logic [stages-1:0]     op_addr_b_o;
  logic [stages-2:0]     op_tw_addr_o;
  logic [stagesbits-1:0] op_stage_o;
  logic [shamtbits-1:0]  op_shamt_o;
  logic                  op_last_o;
  logic                  cmp_valid_i;
  logic                  cmp_grow_i;

  modport master (
    output op_valid_o, op_addr_a_o, op_addr_b_o, op_tw_addr_o,
           op_stage_o, op_shamt_o, op_last_o,
    input  op_ready_i, cmp_valid_i, cmp_grow_i
  );

  modport slave (
    input  op_valid_o, op_addr_a_o, op_addr_b_o, op_tw_addr_o,
           op_stage_o, op_shamt_o, op_last_o,
    output op_ready_i, cmp_valid_i, cmp_grow_i
  );
endinterface

// File: rtl/fft_stage_scheduler.sv
// Radix-2 in-place FFT stage/butterfly sequencer with block-floating-point shift tracking.
// Define FFT_SCHED_PERF_CNT_EN to enable the cycles_o run cycle counter.
module fft_stage_scheduler #(
  parameter int points      = 1024,
  parameter int stages      = 10,
  parameter int stagesbits  = 4,
  parameter int maxshifts   = 8,
  parameter int shamtbits   = 4,
  parameter int maxinflight = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 run_i,
  output logic                 busy_o,
  output logic                 done_o,
  fft_stage_scheduler_if.master op,
  output logic [maxshifts-1:0] total_shifts,
  output logic                 err_o,
  output logic [31:0]          cycles_o
);

  localparam int pairbits = stages - 1;
  localparam logic [pairbits-1:0]   last_pair  = pairbits'(points / 2 - 1);
  localparam logic [stagesbits-1:0] last_stage = stagesbits'(stages - 1);
  localparam logic [3:0]            max_fly    = 4'(maxinflight);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, NEXT, DONE} state_t;

  state_t                state;
  logic [stagesbits-1:0] s;
  logic [pairbits-1:0]   p;
  logic [3:0]            inflight;
  logic [3:0]            inflight_next;
  logic                  grow;
  logic                  valid_q;
  logic [shamtbits-1:0]  shamt;
  logic                  handshake;
  logic                  cmp_err;

  logic [stages-1:0]     span;
  logic [stages-1:0]     pair_ext;
  logic [stages-1:0]     low;
  logic [stages-1:0]     addr_a;
  logic [pairbits-1:0]   tw;

  assign handshake = valid_q && op.op_ready_i;
  assign cmp_err   = op.cmp_valid_i && (inflight == 4'd0);

  // Pair p splits into a block index (upper bits) and an offset inside the span.
  assign span     = stages'(1) << s;
  assign pair_ext = {1'b0, p};
  assign low      = pair_ext & (span - stages'(1));
  assign addr_a   = ((pair_ext >> s) << (s + 1'b1)) | low;
  assign tw       = pairbits'(low) << (last_stage - s);

  // Descriptor fields read zero whenever no run is active.
  assign op.op_valid_o   = valid_q;
  assign op.op_addr_a_o  = busy_o ? addr_a : '0;
  assign op.op_addr_b_o  = busy_o ? (addr_a + span) : '0;
  assign op.op_tw_addr_o = busy_o ? tw : '0;
  assign op.op_stage_o   = busy_o ? s : '0;
  assign op.op_shamt_o   = busy_o ? shamt : '0;
  assign op.op_last_o    = busy_o && (p == last_pair);

  always_comb begin
    inflight_next = inflight;
    if (handshake && !op.cmp_valid_i) begin
      inflight_next = inflight + 4'd1;
    end else if (!handshake && op.cmp_valid_i && inflight != 4'd0) begin
      inflight_next = inflight - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state        <= IDLE;
      s            <= '0;
      p            <= '0;
      inflight     <= '0;
      grow         <= 1'b0;
      valid_q      <= 1'b0;
      shamt        <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      total_shifts <= '0;
      err_o        <= 1'b0;
    end else begin
      inflight <= inflight_next;
      done_o   <= 1'b0;
      if (cmp_err) begin
        err_o <= 1'b1;
      end
      if (op.cmp_valid_i && op.cmp_grow_i) begin
        grow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (run_i) begin
            state        <= ISSUE;
            busy_o       <= 1'b1;
            s            <= '0;
            p            <= '0;
            shamt        <= '0;
            grow         <= 1'b0;
            total_shifts <= '0;
            err_o        <= cmp_err;
            valid_q      <= (inflight_next < max_fly);
          end
        end
        ISSUE: begin
          valid_q <= (inflight_next < max_fly);
          if (handshake) begin
            if (p == last_pair) begin
              state   <= DRAIN;
              valid_q <= 1'b0;
            end else begin
              p <= p + 1'b1;
            end
          end
        end
        // Later stages read what this stage wrote, so every butterfly must retire first.
        DRAIN: begin
          if (inflight == 4'd0) begin
            if (s == last_stage) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              state <= NEXT;
            end
          end
        end
        NEXT: begin
          state   <= ISSUE;
          s       <= s + 1'b1;
          p       <= '0;
          grow    <= 1'b0;
          shamt   <= grow ? shamtbits'(1) : '0;
          valid_q <= (inflight_next < max_fly);
          if (grow && total_shifts != {maxshifts{1'b1}}) begin
            total_shifts <= total_shifts + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FFT_SCHED_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cycles_o <= '0;
    end else if (state == IDLE && run_i) begin
      cycles_o <= '0;
    end else if (busy_o) begin
      cycles_o <= cycles_o + 32'd1;
    end
  end
`else
  assign cycles_o = '0;
`endif

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Scoreboard bench for fft_stage_scheduler on an 8-point FFT with at most 2 butterflies in flight.
// A PE model retires each butterfly two cycles after issue; a monitor checks descriptors and done pulses.
module tb_fft_stage_scheduler;

  localparam int POINTS      = 8;
  localparam int STAGES      = 3;
  localparam int STAGESBITS  = 4;
  localparam int MAXSHIFTS   = 8;
  localparam int SHAMTBITS   = 4;
  localparam int MAXINFLIGHT = 2;
  localparam int NHS         = STAGES * POINTS / 2;

  typedef struct {
    int a;
    int b;
    int tw;
    int stage;
    int shamt;
    int last;
  } desc_t;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 run = 1'b0;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [MAXSHIFTS-1:0] total_shifts;
  logic [31:0]          cycles;

  fft_stage_scheduler_if #(
    .stages(STAGES), .stagesbits(STAGESBITS), .shamtbits(SHAMTBITS)
  ) op_if ();

  fft_stage_scheduler #(
    .points(POINTS), .stages(STAGES), .stagesbits(STAGESBITS),
    .maxshifts(MAXSHIFTS), .shamtbits(SHAMTBITS), .maxinflight(MAXINFLIGHT)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .run_i(run),
    .busy_o(busy),
    .done_o(done),
    .op(op_if),
    .total_shifts(total_shifts),
    .err_o(err),
    .cycles_o(cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  desc_t exp_q[$];
  int    exp_done_q[$];
  int    pend_due[$];
  bit    pend_grow[$];

  int cyc        = 0;
  int hs_count   = 0;
  int mon_hs     = 0;
  int cmp_seen   = 0;
  int done_count = 0;
  int grow_hs0   = -1;
  int grow_hs1   = -1;
  bit pe_hold    = 1'b0;
  bit ready_mode = 1'b0;
  bit force_cmp  = 1'b0;

  // Hand-computed (a, b, tw) for the 12 butterflies of an 8-point transform.
  int exp_a[NHS]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b[NHS]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw[NHS] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int g0, input int g1, input int sh1, input int sh2);
    desc_t d;
    for (int i = 0; i < NHS; i++) begin
      d.a     = exp_a[i];
      d.b     = exp_b[i];
      d.tw    = exp_tw[i];
      d.stage = i / (POINTS / 2);
      d.shamt = (d.stage == 0) ? 0 : ((d.stage == 1) ? sh1 : sh2);
      d.last  = (i % (POINTS / 2) == POINTS / 2 - 1) ? 1 : 0;
      exp_q.push_back(d);
    end
    exp_done_q.push_back(sh1 + sh2);
    grow_hs0 = g0;
    grow_hs1 = g1;
    hs_count = 0;
    mon_hs   = 0;
    cmp_seen = 0;
    run = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
  endtask

  task automatic waitRunDone(input int bound);
    int start_count = done_count;
    int n = 0;
    while (done_count == start_count && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_count == start_count) checkOutput("run_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic flushScoreboard();
    exp_q.delete();
    exp_done_q.delete();
    pend_due.delete();
    pend_grow.delete();
  endtask

  // PE model: drives ready and schedules retirements for the upcoming edge.
  initial begin
    op_if.op_ready_i  = 1'b0;
    op_if.cmp_valid_i = 1'b0;
    op_if.cmp_grow_i  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      op_if.op_ready_i  = ready_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      op_if.cmp_valid_i = 1'b0;
      op_if.cmp_grow_i  = 1'b0;
      if (force_cmp) begin
        op_if.cmp_valid_i = 1'b1;
        force_cmp = 1'b0;
      end else if (rstn && !pe_hold && pend_due.size() > 0 && pend_due[0] <= cyc) begin
        op_if.cmp_valid_i = 1'b1;
        op_if.cmp_grow_i  = pend_grow.pop_front();
        void'(pend_due.pop_front());
        cmp_seen++;
      end
      if (rstn && op_if.op_valid_o && op_if.op_ready_i) begin
        pend_due.push_back(cyc + 2);
        pend_grow.push_back(hs_count == grow_hs0 || hs_count == grow_hs1);
        hs_count++;
      end
    end
  end

  // Monitor: compares every presented descriptor with the scoreboard head.
  initial begin
    desc_t d;
    forever begin
      @(negedge clk);
      #1;
      if (rstn && op_if.op_valid_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_descriptor", 1, 0);
        end else begin
          d = exp_q[0];
          checkOutput("addr_a", int'(op_if.op_addr_a_o), d.a);
          checkOutput("addr_b", int'(op_if.op_addr_b_o), d.b);
          checkOutput("tw_addr", int'(op_if.op_tw_addr_o), d.tw);
          checkOutput("stage", int'(op_if.op_stage_o), d.stage);
          checkOutput("shamt", int'(op_if.op_shamt_o), d.shamt);
          checkOutput("last", int'(op_if.op_last_o), d.last);
          if (op_if.op_ready_i) begin
            if (mon_hs > 0 && mon_hs % (POINTS / 2) == 0)
              checkOutput("stage_drained", cmp_seen, mon_hs);
            void'(exp_q.pop_front());
            mon_hs++;
          end
        end
      end
      if (rstn && done) begin
        done_count++;
        if (exp_done_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          checkOutput("total_shifts", int'(total_shifts), exp_done_q.pop_front());
          checkOutput("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_valid", int'(op_if.op_valid_o), 0);
    checkOutput("reset_err", int'(err), 0);
    checkOutput("reset_total", int'(total_shifts), 0);
    checkOutput("reset_addr_b", int'(op_if.op_addr_b_o), 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] plain run, no grow");
    applyStimulus(-1, -1, 0, 0);
    checkOutput("busy_after_start", int'(busy), 1);
    waitRunDone(300);

    $display("[TB] grow in stages 0 and 1");
    applyStimulus(1, 5, 1, 1);
    waitRunDone(300);

    $display("[TB] completions withheld");
    pe_hold = 1'b1;
    applyStimulus(-1, -1, 0, 0);
    n = 0;
    while (hs_count < 2 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("two_issued", hs_count, 2);
    checkOutput("valid_drops_at_limit", int'(op_if.op_valid_o), 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("valid_held_low", int'(op_if.op_valid_o), 0);
    checkOutput("no_third_issue", hs_count, 2);
    pe_hold = 1'b0;
    n = 0;
    while (cmp_seen < 1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("valid_rises_after_cmp", int'(op_if.op_valid_o), 1);
    waitRunDone(300);

    $display("[TB] random ready stalls");
    ready_mode = 1'b1;
    applyStimulus(-1, -1, 0, 0);
    waitRunDone(600);
    ready_mode = 1'b0;

    $display("[TB] completion while idle");
    force_cmp = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("err_set_idle", int'(err), 1);
    checkOutput("busy_idle", int'(busy), 0);
    applyStimulus(-1, -1, 0, 0);
    checkOutput("err_cleared_on_start", int'(err), 0);
    waitRunDone(300);
    checkOutput("err_after_clean_run", int'(err), 0);

    $display("[TB] reset during stage 1");
    applyStimulus(-1, -1, 0, 0);
    n = 0;
    while (hs_count < 5 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("reached_stage1", int'(op_if.op_stage_o), 1);
    rstn = 1'b0;
    flushScoreboard();
    @(posedge clk);
    #1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_valid", int'(op_if.op_valid_o), 0);
    checkOutput("rst_done", int'(done), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    flushScoreboard();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_after_reset", int'(busy), 0);
    applyStimulus(-1, -1, 0, 0);
    waitRunDone(300);

    checkOutput("descriptors_left", exp_q.size(), 0);
    checkOutput("dones_left", exp_done_q.size(), 0);
`ifndef FFT_SCHED_PERF_CNT_EN
    checkOutput("cycles_tied_zero", int'(cycles), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "[TB] global timeout");
  end

endmodule
